// File: rtl/detector_jogada.sv
// Debounced one-hot button press detector feeding the game control unit.
// Define DETECTOR_DEBOUNCE_EN to enable the stability filter; otherwise presses are taken on sight.
module detector_jogada #(
  parameter int DEBOUNCE_CICLOS = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  output logic       jogada,
  output logic [3:0] jogada_valor,
  output logic       jogada_invalida,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO = 4'd0,
    FILTRA = 4'd1,
    PULSO  = 4'd2,
    SOLTA  = 4'd3
  } estado_t;

  localparam logic [15:0] LIMITE = 16'(DEBOUNCE_CICLOS - 1);

  estado_t     estado;
  estado_t     proximo;
  logic [3:0]  sinc;
  logic [3:0]  botoes_s;
  logic [3:0]  amostra;
  logic [3:0]  amostra_next;
  logic [15:0] contador;
  logic [15:0] contador_next;
  logic [15:0] contador_inc;
  logic        invalida_next;

  function automatic logic um_quente(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Saturating increment keeps the counter from ever wrapping.
  assign contador_inc = (contador == LIMITE) ? contador
                                             : contador + 16'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc            <= 4'd0;
      botoes_s        <= 4'd0;
      estado          <= OCIOSO;
      amostra         <= 4'd0;
      contador        <= 16'd0;
      jogada_invalida <= 1'b0;
      jogada_valor    <= 4'd0;
    end else begin
      sinc            <= botoes;
      botoes_s        <= sinc;
      estado          <= proximo;
      amostra         <= amostra_next;
      contador        <= contador_next;
      jogada_invalida <= invalida_next;
      if (proximo == PULSO && estado != PULSO)
        jogada_valor <= amostra_next;
    end
  end

  always_comb begin
    proximo       = estado;
    amostra_next  = amostra;
    contador_next = contador;
    invalida_next = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (botoes_s != 4'd0) begin
          amostra_next  = botoes_s;
          contador_next = 16'd0;
`ifdef DETECTOR_DEBOUNCE_EN
          proximo = FILTRA;
`else
          if (um_quente(botoes_s)) begin
            proximo = PULSO;
          end else begin
            invalida_next = 1'b1;
            proximo       = SOLTA;
          end
`endif
        end
      end
      FILTRA: begin
`ifdef DETECTOR_DEBOUNCE_EN
        if (botoes_s != amostra) begin
          proximo = OCIOSO;
        end else if (contador == LIMITE) begin
          contador_next = 16'd0;
          if (um_quente(amostra)) begin
            proximo = PULSO;
          end else begin
            invalida_next = 1'b1;
            proximo       = SOLTA;
          end
        end else begin
          contador_next = contador_inc;
        end
`else
        proximo = OCIOSO;
`endif
      end
      PULSO: begin
        contador_next = 16'd0;
        proximo       = SOLTA;
      end
      SOLTA: begin
        if (botoes_s != 4'd0)
          contador_next = 16'd0;
        else
          contador_next = contador_inc;
`ifdef DETECTOR_DEBOUNCE_EN
        if (botoes_s == 4'd0 && contador == LIMITE)
          proximo = OCIOSO;
`else
        if (botoes_s == 4'd0)
          proximo = OCIOSO;
`endif
      end
      default: proximo = OCIOSO;
    endcase
  end

  assign jogada = (estado == PULSO);

  always_comb begin
    db_estado = 4'hF;
    if (estado == OCIOSO || estado == FILTRA ||
        estado == PULSO  || estado == SOLTA)
      db_estado = estado;
  end

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with DEBOUNCE_CICLOS=4.
// Covers both the filtered and the unfiltered build.
module tb_detector_jogada;

  logic       clock;
  logic       reset;
  logic [3:0] botoes;
  logic       jogada;
  logic [3:0] jogada_valor;
  logic       jogada_invalida;
  logic [3:0] db_estado;

  int checks   = 0;
  int failures = 0;
  int n_jog;
  int n_inv;
  logic [3:0] exp_db;

  detector_jogada #(.DEBOUNCE_CICLOS(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .botoes          (botoes),
    .jogada          (jogada),
    .jogada_valor    (jogada_valor),
    .jogada_invalida (jogada_invalida),
    .db_estado       (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [3:0] obs,
                       input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clock)
    if (jogada && jogada_invalida) begin
      checks++;
      failures++;
      $error("FAIL both_pulses observed=1 expected=0");
    end

  initial begin
    reset  = 1'b1;
    botoes = 4'd0;
    tick();
    tick();
    check("rst_jogada", {3'd0, jogada}, 4'd0);
    check("rst_valor", jogada_valor, 4'd0);
    check("rst_inv", {3'd0, jogada_invalida}, 4'd0);
    check("rst_db", db_estado, 4'd0);
    reset = 1'b0;
    tick();
    check("idle_db", db_estado, 4'd0);

`ifdef DETECTOR_DEBOUNCE_EN
    // clean press 0100
    botoes = 4'b0100;
    n_jog = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_jog += int'(jogada);
      check("a_jog", {3'd0, jogada}, {3'd0, i == 7});
      exp_db = (i < 3) ? 4'd0 : (i < 7) ? 4'd1 :
               (i == 7) ? 4'd2 : 4'd3;
      check("a_db", db_estado, exp_db);
    end
    check("a_count", 4'(n_jog), 4'd1);
    check("a_valor", jogada_valor, 4'b0100);
    botoes = 4'd0;
    repeat (10) tick();
    check("a_idle", db_estado, 4'd0);

    // short glitch 0001
    botoes = 4'b0001;
    tick();
    tick();
    botoes = 4'd0;
    n_jog = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_jog += int'(jogada);
    end
    check("b_count", 4'(n_jog), 4'd0);
    check("b_db", db_estado, 4'd0);
    check("b_valor", jogada_valor, 4'b0100);

    // two buttons 0011
    botoes = 4'b0011;
    n_jog = 0;
    n_inv = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_jog += int'(jogada);
      n_inv += int'(jogada_invalida);
      check("c_inv", {3'd0, jogada_invalida},
            {3'd0, i == 7});
    end
    check("c_jog", 4'(n_jog), 4'd0);
    check("c_ninv", 4'(n_inv), 4'd1);
    check("c_valor", jogada_valor, 4'b0100);
    botoes = 4'd0;
    repeat (10) tick();
    check("c_idle", db_estado, 4'd0);

    // release bounce 1000
    n_jog = 0;
    botoes = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_jog += int'(jogada);
    end
    botoes = 4'd0;
    tick();
    tick();
    botoes = 4'b1000;
    tick();
    tick();
    botoes = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_jog += int'(jogada);
    end
    check("d_solta", db_estado, 4'd3);
    tick();
    n_jog += int'(jogada);
    check("d_ocioso", db_estado, 4'd0);
    check("d_count", 4'(n_jog), 4'd1);
    check("d_valor", jogada_valor, 4'b1000);

    // reset mid-filter with 0010
    botoes = 4'b0010;
    repeat (4) tick();
    check("e_filtra", db_estado, 4'd1);
    reset = 1'b1;
    #1;
    check("e_rst_db", db_estado, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("e_rst_jog", {3'd0, jogada}, 4'd0);
    end
    check("e_rst_valor", jogada_valor, 4'd0);
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("e_jog", {3'd0, jogada}, {3'd0, i == 7});
    end
    check("e_valor", jogada_valor, 4'b0010);
    botoes = 4'd0;
    repeat (10) tick();
    check("e_idle", db_estado, 4'd0);
`else
    // direct mode: hold 0001
    botoes = 4'b0001;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("f_jog", {3'd0, jogada}, {3'd0, i == 3});
      exp_db = (i < 3) ? 4'd0 : (i == 3) ? 4'd2 : 4'd3;
      check("f_db", db_estado, exp_db);
    end
    check("f_valor", jogada_valor, 4'b0001);
    botoes = 4'd0;
    tick();
    botoes = 4'b0001;
    n_jog = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_jog += int'(jogada);
      check("g_jog", {3'd0, jogada}, {3'd0, i == 3});
    end
    check("g_count", 4'(n_jog), 4'd1);
    botoes = 4'd0;
    repeat (4) tick();
    check("g_idle", db_estado, 4'd0);

    // direct mode: two buttons
    botoes = 4'b0011;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("h_inv", {3'd0, jogada_invalida},
            {3'd0, i == 3});
      check("h_jog", {3'd0, jogada}, 4'd0);
      exp_db = (i < 3) ? 4'd0 : 4'd3;
      check("h_db", db_estado, exp_db);
    end
    check("h_valor", jogada_valor, 4'b0001);
    botoes = 4'd0;
    repeat (4) tick();
    check("h_idle", db_estado, 4'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
